// File: rtl/audioport_pkg.sv
// Shared audioport definitions: ping-pong sample buffer sizing, controller
// states and the bank/frame/channel word-address helper.
package audioport_pkg;

  localparam int AUDIO_BUFFER_SIZE = 42;
  localparam int ABUF_CHANNELS     = 2;
  localparam int ABUF_DEPTH        = AUDIO_BUFFER_SIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CLEAR = 2'd2
  } abuf_state_t;

  // Word address of channel ch in frame of bank; banks are stored back to back.
  function automatic int abuf_addr(input int bank, input int frame, input int ch,
                                   input int channels = ABUF_CHANNELS,
                                   input int depth    = ABUF_DEPTH);
    return bank * channels * depth + frame * channels + ch;
  endfunction

endpackage

// File: rtl/abuf_ram.sv
// Sample storage: one write port, one CHANNELS-wide asynchronous frame read.
// A write lands at the clock edge, so a read in the same cycle sees old data.
module abuf_ram
  import audioport_pkg::*;
#(
  parameter int WORDS    = 16,
  parameter int DATA_W   = 24,
  parameter int CHANNELS = 2,
  parameter int ADDR_W   = 4
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            waddr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [ADDR_W-1:0]            raddr,
  output logic [CHANNELS*DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem_q [WORDS];

  // Addresses past the last word exist only when WORDS is not a power of two.
  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < 32'(WORDS))) begin
      mem_q[waddr] <= wdata;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_rd
    assign rdata[c*DATA_W +: DATA_W] = mem_q[raddr + ADDR_W'(c)];
  end

endmodule

// File: rtl/abuf_pingpong.sv
// Ping-pong audio sample buffer: software fills two banks, sample ticks drain
// the active bank frame by frame, bank exhaustion swaps banks and raises irq.
module abuf_pingpong
  import audioport_pkg::*;
#(
  parameter  int CHANNELS    = ABUF_CHANNELS,
  parameter  int BUFFER_SIZE = ABUF_DEPTH,
  parameter  int DATA_W      = 24,
  localparam int WORDS       = 2 * CHANNELS * BUFFER_SIZE,
  localparam int ADDR_W      = $clog2(WORDS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       play_in,
  input  logic                       clr_in,
  input  logic                       tick_in,
  input  logic                       irq_ack_in,
  output logic                       rd_valid,
  output logic [CHANNELS*DATA_W-1:0] rd_data,
  output logic                       active_bank,
  output logic                       irq_out,
  output logic                       underrun,
  output logic                       busy
);

  localparam int PTR_W   = $clog2(BUFFER_SIZE);
  localparam int FRAME_W = CHANNELS * DATA_W;

  abuf_state_t        state_q, state_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic               bank_q, bank_d;
  logic               irq_q, irq_d;
  logic               underrun_q, underrun_d;
  logic               rd_valid_q, rd_valid_d;
  logic [FRAME_W-1:0] rd_data_q, rd_data_d;

  logic               ram_we;
  logic [ADDR_W-1:0]  ram_waddr, ram_raddr;
  logic [DATA_W-1:0]  ram_wdata;
  logic [FRAME_W-1:0] ram_rdata;
  logic               playing;
  logic               swap;

  // A tick only reads memory while playback is running and not being cleared.
  assign playing   = (state_q == PLAY) && play_in && !clr_in;
  assign swap      = playing && tick_in && (rd_ptr_q == PTR_W'(BUFFER_SIZE - 1));
  assign ram_raddr = ADDR_W'(abuf_addr(int'(bank_q), int'(rd_ptr_q), 0, CHANNELS, BUFFER_SIZE));

  abuf_ram #(
    .WORDS    (WORDS),
    .DATA_W   (DATA_W),
    .CHANNELS (CHANNELS),
    .ADDR_W   (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // The clear sequencer owns the write port for the whole CLEAR state.
  always_comb begin
    ram_we    = wr_en;
    ram_waddr = wr_addr;
    ram_wdata = wr_data;
    if (state_q == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt_q;
      ram_wdata = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    clr_cnt_d  = clr_cnt_q;
    bank_d     = bank_q;
    irq_d      = irq_q;
    underrun_d = underrun_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;

    if (tick_in && (state_q != CLEAR) && !clr_in) begin
      rd_valid_d = 1'b1;
      if (playing) begin
        rd_data_d = ram_rdata;
        rd_ptr_d  = swap ? '0 : rd_ptr_q + PTR_W'(1);
        if (swap) bank_d = ~bank_q;
      end else begin
        rd_data_d = '0;
      end
    end

    // A swap outranks a same-cycle ack, and that ack counts as servicing.
    if (swap) begin
      irq_d = 1'b1;
      if (irq_q && !irq_ack_in) underrun_d = 1'b1;
    end else if (irq_ack_in) begin
      irq_d = 1'b0;
    end

    if (clr_in) begin
      state_d   = CLEAR;
      clr_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (play_in) begin
            state_d  = PLAY;
            rd_ptr_d = '0;
            bank_d   = 1'b0;
          end
        end
        PLAY: begin
          if (!play_in) begin
            state_d  = IDLE;
            rd_ptr_d = '0;
            bank_d   = 1'b0;
          end
        end
        CLEAR: begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == ADDR_W'(WORDS - 1)) begin
            state_d    = IDLE;
            clr_cnt_d  = '0;
            rd_ptr_d   = '0;
            bank_d     = 1'b0;
            irq_d      = 1'b0;
            underrun_d = 1'b0;
            rd_data_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      clr_cnt_q  <= '0;
      bank_q     <= 1'b0;
      irq_q      <= 1'b0;
      underrun_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      clr_cnt_q  <= clr_cnt_d;
      bank_q     <= bank_d;
      irq_q      <= irq_d;
      underrun_q <= underrun_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign active_bank = bank_q;
  assign irq_out     = irq_q;
  assign underrun    = underrun_q;
  assign busy        = (state_q == CLEAR);

endmodule

// File: tb/tb_abuf_pingpong.sv
// Bench for abuf_pingpong: directed scenarios then random traffic, with frames
// scored against a bank/frame reference model through an expected-frame queue.
module tb_abuf_pingpong;

  localparam int CH    = 2;
  localparam int BS    = 4;
  localparam int DW    = 24;
  localparam int WORDS = 2 * CH * BS;
  localparam int AW    = 4;
  localparam int FW    = CH * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          play_in = 1'b0;
  logic          clr_in = 1'b0;
  logic          tick_in = 1'b0;
  logic          irq_ack_in = 1'b0;
  logic          rd_valid;
  logic [FW-1:0] rd_data;
  logic          active_bank;
  logic          irq_out;
  logic          underrun;
  logic          busy;

  int errors = 0;
  int checks = 0;

  abuf_pingpong #(.CHANNELS(CH), .BUFFER_SIZE(BS), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .play_in     (play_in),
    .clr_in      (clr_in),
    .tick_in     (tick_in),
    .irq_ack_in  (irq_ack_in),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .active_bank (active_bank),
    .irq_out     (irq_out),
    .underrun    (underrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 play, 2 clear.
  logic [DW-1:0] m_mem [WORDS];
  int            m_mode, m_ptr, m_bank, m_left;
  bit            m_irq, m_und;
  logic [FW-1:0] m_last;
  logic [FW-1:0] exp_q [$];
  logic [FW-1:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_ptr = 0; m_bank = 0; m_left = 0;
    m_irq = 1'b0; m_und = 1'b0; m_last = '0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit we, input int addr, input logic [DW-1:0] d,
                            input bit play, input bit clr, input bit tick, input bit ack,
                            output bit pushed);
    bit swap;
    int base;
    swap = 1'b0;
    pushed = 1'b0;
    if (m_mode != 2 && !clr && tick) begin
      pushed = 1'b1;
      if (m_mode == 1 && play) begin
        base   = m_bank * CH * BS + m_ptr * CH;
        m_last = {m_mem[base+1], m_mem[base]};
        swap   = (m_ptr == BS - 1);
        m_ptr  = (m_ptr + 1) % BS;
        if (swap) m_bank = 1 - m_bank;
      end else begin
        m_last = '0;
      end
      exp_q.push_back(m_last);
    end
    if (m_mode != 2 && we && addr < WORDS) m_mem[addr] = d;
    if (swap) begin
      if (m_irq && !ack) m_und = 1'b1;
      m_irq = 1'b1;
    end else if (ack) begin
      m_irq = 1'b0;
    end
    if (clr) begin
      m_mode = 2;
      m_left = WORDS;
    end else if (m_mode == 0) begin
      if (play) begin m_mode = 1; m_ptr = 0; m_bank = 0; end
    end else if (m_mode == 1) begin
      if (!play) begin m_mode = 0; m_ptr = 0; m_bank = 0; end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_mode = 0;
        foreach (m_mem[i]) m_mem[i] = '0;
        m_irq = 1'b0; m_und = 1'b0; m_ptr = 0; m_bank = 0; m_last = '0;
      end
    end
  endtask

  // Called at a negedge: drive one cycle of inputs, then check state at the next negedge.
  task automatic step(input bit we, input int addr, input logic [DW-1:0] d,
                      input bit play, input bit clr, input bit tick, input bit ack);
    bit pushed;
    wr_en = we; wr_addr = AW'(addr); wr_data = d;
    play_in = play; clr_in = clr; tick_in = tick; irq_ack_in = ack;
    model_step(we, addr, d, play, clr, tick, ack, pushed);
    @(negedge clk);
    wr_en = 1'b0; clr_in = 1'b0; tick_in = 1'b0; irq_ack_in = 1'b0;
    check("busy", busy, m_mode == 2);
    check("irq_out", irq_out, m_irq);
    check("underrun", underrun, m_und);
    check("active_bank", active_bank, m_bank != 0);
    check("rd_data_hold", rd_data, m_last);
    if (pushed) check("rd_valid_seen", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_active_bank"}, active_bank, 0);
    check({tag, "_irq_out"}, irq_out, 0);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      step(0, 0, '0, 1, 0, 1, 0);
      step(0, 0, '0, 1, 0, 0, 0);
    end
  endtask

  // Monitor: every rd_valid pulse must match the oldest expected frame.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rd_valid: got rd_data %0h expected no output", rd_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("frame", rd_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected finish before 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cycles;
    foreach (m_mem[i]) m_mem[i] = '0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fill both banks with value = address, then play two full banks.
    for (int a = 0; a < WORDS; a++) step(1, a, DW'(a), 0, 0, 0, 0);
    step(0, 0, '0, 1, 0, 0, 0);
    step(0, 0, '0, 1, 0, 0, 0);
    tick_n(4);
    check("pass0_irq", irq_out, 1);
    check("pass0_bank", active_bank, 1);
    check("pass0_underrun", underrun, 0);
    tick_n(4);
    check("pass1_underrun", underrun, 1);
    check("pass1_bank", active_bank, 0);

    // Clear in the middle of playback, with ticks arriving while busy.
    tick_n(2);
    step(0, 0, '0, 1, 1, 0, 0);
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 40) begin
      step(0, 0, '0, 1, 0, busy_cycles % 2, 0);
      busy_cycles++;
    end
    check("clear_busy_len", busy_cycles, WORDS);
    check_all_zero("after_clear");
    step(0, 0, '0, 1, 0, 1, 0);
    step(0, 0, '0, 1, 0, 0, 0);
    check("silence_after_clear", rd_data, 0);

    // Refill while playing; ack coincides with the swap tick.
    for (int a = 0; a < WORDS; a++) step(1, a, DW'(a), 1, 0, 0, 0);
    tick_n(3);
    step(0, 0, '0, 1, 0, 1, 1);
    step(0, 0, '0, 1, 0, 0, 0);
    check("ack_swap_irq", irq_out, 1);
    check("ack_swap_underrun", underrun, 0);
    check("ack_swap_bank", active_bank, 1);

    // Write to the frame being read in the same cycle: old data comes out.
    tick_n(4);
    step(1, 0, 24'hABCDEF, 1, 0, 1, 0);
    step(0, 0, '0, 1, 0, 0, 0);
    check("same_cycle_old", rd_data[DW-1:0], 0);
    tick_n(7);
    step(0, 0, '0, 1, 0, 1, 0);
    step(0, 0, '0, 1, 0, 0, 0);
    check("next_pass_new", rd_data[DW-1:0], 24'hABCDEF);

    // Asynchronous reset at rd_ptr=2.
    tick_n(1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, '0, 1, 0, 0, 0);
    step(0, 0, '0, 1, 0, 0, 0);
    step(0, 0, '0, 1, 0, 1, 0);
    step(0, 0, '0, 1, 0, 0, 0);
    check("post_reset_frame0", rd_data, {24'd1, 24'hABCDEF});

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      step(($urandom % 3) == 0, int'($urandom % WORDS), DW'($urandom),
           ($urandom % 16) != 0, ($urandom % 97) == 0,
           $urandom % 2, ($urandom % 8) == 0);
    end
    step(0, 0, '0, 1, 0, 0, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
